// File: rtl/hs_stage_arbiter_pkg.sv
// Shared types and helpers for the handshake-stage arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    RTZ
  } arb_state_t;

  localparam int unsigned MAX_N = 8;

  // First set bit of req at or above ptr, wrapping at n back to 0.
  function automatic logic [2:0] rr_first(input logic [MAX_N-1:0] req,
                                          input logic [2:0]       ptr,
                                          input int unsigned      n);
    logic [2:0] win;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      int unsigned idx;
      logic [2:0]  idx3;
      idx  = (32'(ptr) + i) % n;
      idx3 = idx[2:0];
      if ((i < n) && !found && req[idx3]) begin
        win   = idx3;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/hs_stage_arbiter_if.sv
// Requester and stage-side handshake bundle of the arbiter.
interface hs_stage_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 3
);
  localparam int unsigned GW = $clog2(N);

  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ack_o;
  logic           stg_req;
  logic [W-1:0]   stg_data;
  logic           stg_ack;
  logic           busy;
  logic [GW-1:0]  grant_id;

  modport slave (
    input  req_i, data_i, stg_ack,
    output ack_o, stg_req, stg_data, busy, grant_id
  );

  modport master (
    output req_i, data_i, stg_ack,
    input  ack_o, stg_req, stg_data, busy, grant_id
  );
endinterface

// File: rtl/hs_stage_arbiter_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, reset to 0.
module hs_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/hs_stage_arbiter.sv
// Round-robin arbiter sharing one 4-phase bundled-data stage between N requesters.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module hs_stage_arbiter
  import hs_arb_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned W           = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  hs_stage_arbiter_if.slave bus
);

  localparam int unsigned GW = $clog2(N);

  arb_state_t     state, state_nxt;
  logic           ack_s;
  logic           any_req;
  logic           rtz_ok;
  logic [GW-1:0]  win;
  logic [2:0]     win3;
  logic [2:0]     ptr_ext;
  logic [MAX_N-1:0] req_pad;
  logic           do_grant, do_launch, do_ack, do_done;

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.stg_ack),
    .q     (ack_s)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign ptr_ext = '0;
`else
  logic [GW-1:0] ptr;

  always_comb begin
    ptr_ext         = '0;
    ptr_ext[GW-1:0] = ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (do_done) ptr <= (bus.grant_id == GW'(N-1)) ? '0 : bus.grant_id + 1'b1;
  end
`endif

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = bus.req_i & ~bus.ack_o;
    win3           = rr_first(req_pad, ptr_ext, N);
    win            = win3[GW-1:0];
    any_req        = |req_pad;
    rtz_ok         = !ack_s && !bus.req_i[bus.grant_id];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (ack_s)   state_nxt = RTZ;
      RTZ:     if (rtz_ok)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE);
    do_grant  = (state == IDLE) && any_req;
    do_launch = (state == LOAD);
    do_ack    = (state == SEND) && ack_s;
    do_done   = (state == RTZ) && rtz_ok;
  end

  // Handshake outputs are registered so the asynchronous stage never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stg_req  <= 1'b0;
      bus.stg_data <= '0;
      bus.ack_o    <= '0;
      bus.grant_id <= '0;
    end else begin
      if (do_grant) begin
        bus.grant_id <= win;
        bus.stg_data <= bus.data_i[W*32'(win) +: W];
      end
      if (do_launch) bus.stg_req <= 1'b1;
      if (do_ack) begin
        bus.stg_req <= 1'b0;
        bus.ack_o   <= {{(N-1){1'b0}}, 1'b1} << bus.grant_id;
      end
      if (do_done) bus.ack_o <= '0;
    end
  end

endmodule

// File: tb/tb_hs_stage_arbiter.sv
// Directed self-checking bench for hs_stage_arbiter with a behavioural delayed-ack stage.
module tb_hs_stage_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_dly  = 7;

  always #5 clk = ~clk;

  hs_stage_arbiter_if #(.N(4), .W(3)) bus ();

  hs_stage_arbiter #(.N(4), .W(3), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stage model: ack follows req after ack_dly ns; the stage shares rst_n.
  initial begin
    bus.stg_ack = 1'b0;
    forever begin
      wait (bus.stg_req === 1'b1);
      #(ack_dly);
      if (rst_n) bus.stg_ack = 1'b1;
      wait (bus.stg_req === 1'b0);
      #(ack_dly);
      bus.stg_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ack_o != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_req(input int k, output bit ok);
    bus.req_i[k] = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.stg_req !== 1'b0) begin n_fail++; $display("FAIL reset_stg_req: got %b want 0", bus.stg_req); end
    n_checks++; if (bus.stg_data !== 3'd0) begin n_fail++; $display("FAIL reset_stg_data: got %0d want 0", bus.stg_data); end
    n_checks++; if (bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ack_o: got %b want 0000", bus.ack_o); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
  endtask

  task automatic test_single;
    bit ok;
    int lat;
    bus.data_i[5:3] = 3'd5;
    bus.req_i = 4'b0010;
    @(negedge clk);
    n_checks++; if (bus.stg_data !== 3'd5) begin n_fail++; $display("FAIL single_data: got %0d want 5", bus.stg_data); end
    n_checks++; if (bus.stg_req !== 1'b0) begin n_fail++; $display("FAIL single_setup: stg_req %b want 0", bus.stg_req); end
    n_checks++; if (bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d want 1", bus.grant_id); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.stg_req !== 1'b1) begin n_fail++; $display("FAIL single_stg_req: got %b want 1", bus.stg_req); end
    lat = 0;
    while (bus.ack_o == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 3", lat); end
    n_checks++; if (bus.ack_o !== 4'b0010) begin n_fail++; $display("FAIL single_ack: got %b want 0010", bus.ack_o); end
    n_checks++; if (bus.stg_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b want 0", bus.stg_req); end
    release_req(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_idle: busy stuck %b want 0", bus.busy); end
    n_checks++; if (bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL single_rtz_ack: got %b want 0000", bus.ack_o); end
    // Pointer now 2: requests on 1 and 3 must pick 3 (fixed priority picks 1).
    bus.data_i[5:3] = 3'd2;
    bus.req_i = 4'b1010;
    wait_ack(ok);
`ifdef ARB_FIXED_PRIO_EN
    n_checks++; if (!ok || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL single_ptr: grant %0d want 1", bus.grant_id); end
`else
    n_checks++; if (!ok || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL single_ptr: grant %0d want 3", bus.grant_id); end
`endif
    bus.req_i = 4'b0000;
    wait_idle(ok);
  endtask

  task automatic test_all_requests;
    bit ok;
`ifdef ARB_FIXED_PRIO_EN
    int exp_gid[5] = '{0, 0, 1, 2, 3};
`else
    int exp_gid[5] = '{0, 1, 2, 3, 0};
`endif
    bus.req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL all_timeout: txn %0d no ack", i); end
      n_checks++; if (bus.grant_id !== 2'(exp_gid[i])) begin n_fail++; $display("FAIL all_order: txn %0d grant %0d want %0d", i, bus.grant_id, exp_gid[i]); end
      n_checks++; if (bus.ack_o !== (4'b0001 << exp_gid[i])) begin n_fail++; $display("FAIL all_ack: txn %0d ack_o %b want one-hot %0d", i, bus.ack_o, exp_gid[i]); end
      n_checks++; if (bus.stg_data !== 3'(exp_gid[i] + 1)) begin n_fail++; $display("FAIL all_data: txn %0d data %0d want %0d", i, bus.stg_data, exp_gid[i] + 1); end
      release_req(int'(bus.grant_id), ok);
      if (i == 0) bus.req_i[0] = 1'b1;
    end
    bus.req_i = 4'b0000;
  endtask

  task automatic test_wrap;
    bit ok;
`ifdef ARB_FIXED_PRIO_EN
    int exp_gid[2] = '{0, 3};
`else
    int exp_gid[2] = '{3, 0};
`endif
    bus.req_i = 4'b0100;
    wait_ack(ok);
    n_checks++; if (!ok || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL wrap_pre: grant %0d want 2", bus.grant_id); end
    release_req(2, ok);
    bus.req_i = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      wait_ack(ok);
      n_checks++; if (!ok || bus.grant_id !== 2'(exp_gid[i])) begin n_fail++; $display("FAIL wrap_order: txn %0d grant %0d want %0d", i, bus.grant_id, exp_gid[i]); end
      release_req(int'(bus.grant_id), ok);
    end
    bus.req_i = 4'b0000;
  endtask

  task automatic test_slow_requester;
    bit ok;
    bus.req_i = 4'b0001;
    wait_ack(ok);
    n_checks++; if (!ok || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL slow_grant: grant %0d want 0", bus.grant_id); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 4) bus.req_i[2] = 1'b1;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.stg_req !== 1'b0 || bus.ack_o !== 4'b0001 || bus.grant_id !== 2'd0) begin
        n_fail++;
        $display("FAIL slow_hold: cycle %0d busy %b stg_req %b ack_o %b grant %0d want 1 0 0001 0",
                 c, bus.busy, bus.stg_req, bus.ack_o, bus.grant_id);
      end
    end
    release_req(0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL slow_release: busy %b want 0", bus.busy); end
    wait_ack(ok);
    n_checks++; if (!ok || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL slow_next: grant %0d want 2", bus.grant_id); end
    release_req(2, ok);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus.req_i = 4'b0010;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.stg_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_send: stg_req %b want 1", bus.stg_req); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.stg_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_stg_req: got %b want 0", bus.stg_req); end
    n_checks++; if (bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0000", bus.ack_o); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_grant: got %0d want 0", bus.grant_id); end
    bus.req_i = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.req_i = 4'b1001;
    wait_ack(ok);
    n_checks++; if (!ok || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_first: grant %0d want 0", bus.grant_id); end
    bus.req_i = 4'b0000;
    wait_idle(ok);
  endtask

`ifdef ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio;
    bit ok;
    bus.req_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wait_ack(ok);
      n_checks++; if (!ok || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL fixed_prio: txn %0d grant %0d want 0", i, bus.grant_id); end
      release_req(0, ok);
      bus.req_i[0] = 1'b1;
    end
    bus.req_i = 4'b0000;
    wait_idle(ok);
  endtask
`endif

  initial begin
    bus.req_i  = 4'b0000;
    bus.data_i = {3'd4, 3'd3, 3'd2, 3'd1};
    test_reset();
    test_single();
    test_all_requests();
    test_wrap();
    test_slow_requester();
    test_reset_mid();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
